// File: rtl/biriscv_decode_pkg.sv
// Shared definitions for the decode queue: class flag layout and the
// opcode mask/match helper used by the per-lane decoder.
package biriscv_decode_pkg;

    localparam int CLASS_W     = 9;
    localparam int CLS_EXEC    = 0;
    localparam int CLS_LSU     = 1;
    localparam int CLS_BRANCH  = 2;
    localparam int CLS_MUL     = 3;
    localparam int CLS_DIV     = 4;
    localparam int CLS_CSR     = 5;
    localparam int CLS_INVALID = 6;
    localparam int CLS_RD      = 7;
    localparam int CLS_FAULT   = 8;

    localparam logic [31:0] M_OPC    = 32'h0000_007f;
    localparam logic [31:0] M_F3     = 32'h0000_707f;
    localparam logic [31:0] M_SH     = 32'hfc00_707f;
    localparam logic [31:0] M_R      = 32'hfe00_707f;
    localparam logic [31:0] M_MD     = 32'hfe00_407f;
    localparam logic [31:0] M_ALL    = 32'hffff_ffff;
    localparam logic [31:0] M_SFENCE = 32'hfe00_7fff;

    function automatic logic op_hit(input logic [31:0] op, input logic [31:0] mask,
                                    input logic [31:0] match);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/biriscv_decode_lane.sv
// Combinational classifier for one fetch lane; the result is stored with the
// entry so the issue-side read path is pure muxing.
module biriscv_decode_lane
    import biriscv_decode_pkg::*;
(
    input  logic [31:0]        opcode_i,
    input  logic               fault_i,
    input  logic               enable_muldiv_i,
    output logic [CLASS_W-1:0] class_o
);

    logic w_alu, w_load, w_store, w_jump, w_bcond, w_mul, w_div, w_sys, w_csr_rw, w_legal;

    assign w_alu = op_hit(opcode_i, M_F3, 32'h0000_0013) | op_hit(opcode_i, M_F3, 32'h0000_2013)
                 | op_hit(opcode_i, M_F3, 32'h0000_3013) | op_hit(opcode_i, M_F3, 32'h0000_4013)
                 | op_hit(opcode_i, M_F3, 32'h0000_6013) | op_hit(opcode_i, M_F3, 32'h0000_7013)
                 | op_hit(opcode_i, M_SH, 32'h0000_1013) | op_hit(opcode_i, M_SH, 32'h0000_5013)
                 | op_hit(opcode_i, M_SH, 32'h4000_5013)
                 | op_hit(opcode_i, M_OPC, 32'h0000_0037) | op_hit(opcode_i, M_OPC, 32'h0000_0017)
                 | op_hit(opcode_i, M_R, 32'h0000_0033) | op_hit(opcode_i, M_R, 32'h4000_0033)
                 | op_hit(opcode_i, M_R, 32'h0000_1033) | op_hit(opcode_i, M_R, 32'h0000_2033)
                 | op_hit(opcode_i, M_R, 32'h0000_3033) | op_hit(opcode_i, M_R, 32'h0000_4033)
                 | op_hit(opcode_i, M_R, 32'h0000_5033) | op_hit(opcode_i, M_R, 32'h4000_5033)
                 | op_hit(opcode_i, M_R, 32'h0000_6033) | op_hit(opcode_i, M_R, 32'h0000_7033);

    assign w_load  = op_hit(opcode_i, M_F3, 32'h0000_0003) | op_hit(opcode_i, M_F3, 32'h0000_1003)
                   | op_hit(opcode_i, M_F3, 32'h0000_2003) | op_hit(opcode_i, M_F3, 32'h0000_4003)
                   | op_hit(opcode_i, M_F3, 32'h0000_5003) | op_hit(opcode_i, M_F3, 32'h0000_6003);
    assign w_store = op_hit(opcode_i, M_F3, 32'h0000_0023) | op_hit(opcode_i, M_F3, 32'h0000_1023)
                   | op_hit(opcode_i, M_F3, 32'h0000_2023);

    assign w_jump  = op_hit(opcode_i, M_OPC, 32'h0000_006f) | op_hit(opcode_i, M_F3, 32'h0000_0067);
    assign w_bcond = op_hit(opcode_i, M_F3, 32'h0000_0063) | op_hit(opcode_i, M_F3, 32'h0000_1063)
                   | op_hit(opcode_i, M_F3, 32'h0000_4063) | op_hit(opcode_i, M_F3, 32'h0000_5063)
                   | op_hit(opcode_i, M_F3, 32'h0000_6063) | op_hit(opcode_i, M_F3, 32'h0000_7063);

    // M-extension ops become illegal (and thus trap via csr) when disabled
    assign w_mul = enable_muldiv_i & op_hit(opcode_i, M_MD, 32'h0200_0033);
    assign w_div = enable_muldiv_i & op_hit(opcode_i, M_MD, 32'h0200_4033);

    assign w_sys    = op_hit(opcode_i, M_ALL, 32'h0000_0073) | op_hit(opcode_i, M_ALL, 32'h0010_0073)
                    | op_hit(opcode_i, M_ALL, 32'h3020_0073) | op_hit(opcode_i, M_ALL, 32'h1050_0073)
                    | op_hit(opcode_i, M_F3, 32'h0000_000f)  | op_hit(opcode_i, M_F3, 32'h0000_100f)
                    | op_hit(opcode_i, M_SFENCE, 32'h1200_0073);
    assign w_csr_rw = op_hit(opcode_i, M_F3, 32'h0000_1073) | op_hit(opcode_i, M_F3, 32'h0000_2073)
                    | op_hit(opcode_i, M_F3, 32'h0000_3073) | op_hit(opcode_i, M_F3, 32'h0000_5073)
                    | op_hit(opcode_i, M_F3, 32'h0000_6073) | op_hit(opcode_i, M_F3, 32'h0000_7073);

    assign w_legal = w_alu | w_load | w_store | w_jump | w_bcond | w_mul | w_div | w_sys | w_csr_rw;

    always_comb begin
        class_o = '0;
        if (fault_i) begin
            class_o[CLS_CSR]   = 1'b1;
            class_o[CLS_FAULT] = 1'b1;
        end else if (!w_legal) begin
            class_o[CLS_CSR]     = 1'b1;
            class_o[CLS_INVALID] = 1'b1;
        end else begin
            class_o[CLS_EXEC]   = w_alu;
            class_o[CLS_LSU]    = w_load | w_store;
            class_o[CLS_BRANCH] = w_jump | w_bcond;
            class_o[CLS_MUL]    = w_mul;
            class_o[CLS_DIV]    = w_div;
            class_o[CLS_CSR]    = w_sys | w_csr_rw;
            class_o[CLS_RD]     = w_alu | w_load | w_jump | w_csr_rw | w_mul | w_div;
        end
    end

endmodule

// File: rtl/biriscv_decode_queue.sv
// Multi-lane decode queue: classifies fetch bundles on write, stores them in a
// small circular buffer and presents up to LANES head entries to issue.
module biriscv_decode_queue
    import biriscv_decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_muldiv_i,
    input  logic                         flush_i,
    input  logic                         fetch_valid_i,
    input  logic [LANES-1:0]             fetch_lane_valid_i,
    input  logic [LANES*32-1:0]          fetch_instr_i,
    input  logic [31:0]                  fetch_pc_i,
    input  logic [LANES-1:0]             fetch_fault_i,
    output logic                         fetch_accept_o,
    output logic [LANES-1:0]             out_valid_o,
    output logic [LANES*32-1:0]          out_instr_o,
    output logic [LANES*32-1:0]          out_pc_o,
    output logic [LANES*CLASS_W-1:0]     out_class_o,
    input  logic [$clog2(LANES+1)-1:0]   out_pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]        r_instr [DEPTH];
    logic [31:0]        r_pc    [DEPTH];
    logic [CLASS_W-1:0] r_class [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [CLASS_W-1:0] w_lane_class [LANES];
    logic               w_push;
    logic [CNT_W-1:0]   w_push_n, w_pop_n;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        biriscv_decode_lane u_lane (
            .opcode_i        (fetch_instr_i[32*g +: 32]),
            .fault_i         (fetch_fault_i[g]),
            .enable_muldiv_i (enable_muldiv_i),
            .class_o         (w_lane_class[g])
        );
    end

    // Accept depends only on the registered count, never on this cycle's pop
    assign fetch_accept_o = (CNT_W'(DEPTH) - r_count) >= CNT_W'(LANES);
    assign w_push         = fetch_valid_i & fetch_accept_o & ~flush_i;
    assign level_o        = r_count;

    always_comb begin
        w_push_n = '0;
        for (int j = 0; j < LANES; j++) begin
            w_push_n = w_push_n + CNT_W'(fetch_lane_valid_i[j]);
        end
        if (!w_push) begin
            w_push_n = '0;
        end
        w_pop_n = (CNT_W'(out_pop_i) > r_count) ? r_count : CNT_W'(out_pop_i);
    end

    always_comb begin
        out_valid_o = '0;
        out_instr_o = '0;
        out_pc_o    = '0;
        out_class_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_count > CNT_W'(k)) begin
                out_valid_o[k]                = 1'b1;
                out_instr_o[32*k +: 32]       = r_instr[r_rd_ptr + PTR_W'(k)];
                out_pc_o[32*k +: 32]          = r_pc[r_rd_ptr + PTR_W'(k)];
                out_class_o[CLASS_W*k +: CLASS_W] = r_class[r_rd_ptr + PTR_W'(k)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            r_count  <= r_count + w_push_n - w_pop_n;
        end
    end

    // Payload storage carries no reset; lane valids are contiguous from lane 0
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int j = 0; j < LANES; j++) begin
                if (fetch_lane_valid_i[j]) begin
                    r_instr[r_wr_ptr + PTR_W'(j)] <= fetch_instr_i[32*j +: 32];
                    r_pc[r_wr_ptr + PTR_W'(j)]    <= fetch_pc_i + 32'(4 * j);
                    r_class[r_wr_ptr + PTR_W'(j)] <= w_lane_class[j];
                end
            end
        end
        if (rst_ni && !flush_i) begin
            assert (CNT_W'(out_pop_i) <= r_count)
                else $error("decode queue: pop %0d exceeds level %0d", out_pop_i, r_count);
        end
    end

endmodule

// File: tb/tb_biriscv_decode_queue.sv
// Bench for biriscv_decode_queue: directed scenarios followed by random traffic,
// checked against a field-level RISC-V decoder and a queue-based occupancy model.
module tb_biriscv_decode_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 9;
    localparam int POP_W = $clog2(LANES + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst_ni, enable_muldiv_i, flush_i, fetch_valid_i, fetch_accept_o;
    logic [LANES-1:0]      fetch_lane_valid_i, fetch_fault_i, out_valid_o;
    logic [LANES*32-1:0]   fetch_instr_i, out_instr_o, out_pc_o;
    logic [31:0]           fetch_pc_i;
    logic [LANES*CW-1:0]   out_class_o;
    logic [POP_W-1:0]      out_pop_i;
    logic [LVL_W-1:0]      level_o;

    always #5 clk = ~clk;

    biriscv_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .enable_muldiv_i    (enable_muldiv_i),
        .flush_i            (flush_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_lane_valid_i (fetch_lane_valid_i),
        .fetch_instr_i      (fetch_instr_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_fault_i      (fetch_fault_i),
        .fetch_accept_o     (fetch_accept_o),
        .out_valid_o        (out_valid_o),
        .out_instr_o        (out_instr_o),
        .out_pc_o           (out_pc_o),
        .out_class_o        (out_class_o),
        .out_pop_i          (out_pop_i),
        .level_o            (level_o)
    );

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [CW-1:0] cls;
    } ent_t;

    ent_t model_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference decoder written from opcode/funct fields
    function automatic logic [CW-1:0] model_class(input logic [31:0] op, input logic fault,
                                                  input logic md);
        logic [6:0] opc = op[6:0];
        logic [2:0] f3  = op[14:12];
        logic [6:0] f7  = op[31:25];
        logic ex = 0, ls = 0, br = 0, mu = 0, dv = 0, cs = 0, rd = 0, ok = 1;
        if (fault) return 9'h120;
        case (opc)
            7'h37, 7'h17: begin ex = 1; rd = 1; end
            7'h6f: begin br = 1; rd = 1; end
            7'h67: if (f3 == 0) begin br = 1; rd = 1; end else ok = 0;
            7'h63: if (f3 != 2 && f3 != 3) br = 1; else ok = 0;
            7'h03: if (f3 != 3 && f3 != 7) begin ls = 1; rd = 1; end else ok = 0;
            7'h23: if (f3 <= 2) ls = 1; else ok = 0;
            7'h13: begin
                ok = (f3 == 1) ? (op[31:26] == 6'h00)
                   : (f3 == 5) ? (op[31:26] == 6'h00 || op[31:26] == 6'h10) : 1'b1;
                ex = ok; rd = ok;
            end
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin ex = 1; rd = 1; end
                   else if (f7 == 7'h01 && md) begin mu = (f3 < 4); dv = (f3 >= 4); rd = 1; end
                   else ok = 0;
            7'h73: if (f3 != 0 && f3 != 4) begin cs = 1; rd = 1; end
                   else if (op == 32'h73 || op == 32'h100073 || op == 32'h30200073 ||
                            op == 32'h10500073 || (op & 32'hfe007fff) == 32'h12000073) cs = 1;
                   else ok = 0;
            7'h0f: if (f3 <= 1) cs = 1; else ok = 0;
            default: ok = 0;
        endcase
        if (!ok) return 9'h060;
        return {1'b0, rd, 1'b0, cs, dv, mu, br, ls, ex};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 12))
            0:  return r;
            1:  return {r[31:7], 7'h37};
            2:  return {r[31:7], 7'h17};
            3:  return {r[31:7], 7'h6f};
            4:  return {r[31:7], 7'h67};
            5:  return {r[31:7], 7'h63};
            6:  return {r[31:7], 7'h03};
            7:  return {r[31:7], 7'h23};
            8:  return {r[31:7], 7'h13};
            9: begin
                case (r[1:0])
                    2'd0: f7 = 7'h00;
                    2'd1: f7 = 7'h20;
                    2'd2: f7 = 7'h01;
                    default: f7 = r[31:25];
                endcase
                return {f7, r[24:7], 7'h33};
            end
            10: return {r[31:7], 7'h73};
            11: case (r[2:0])
                    3'd0: return 32'h00000073;
                    3'd1: return 32'h00100073;
                    3'd2: return 32'h30200073;
                    3'd3: return 32'h10500073;
                    3'd4: return {7'h09, r[24:15], 3'b000, 5'b00000, 7'h73};
                    default: return {r[31:7], 7'h0f};
                endcase
            default: return {(r[0] ? 6'h10 : 6'h00), r[25:15], (r[1] ? 3'b101 : 3'b001),
                             r[11:7], 7'h13};
        endcase
    endfunction

    task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        ent_t e;
        bit   v;
        for (int k = 0; k < LANES; k++) begin
            v = (k < model_q.size());
            if (v) e = model_q[k];
            else begin e.instr = '0; e.pc = '0; e.cls = '0; end
            expect_eq($sformatf("%s valid%0d", tag, k), 64'(out_valid_o[k]), 64'(v));
            expect_eq($sformatf("%s instr%0d", tag, k), 64'(out_instr_o[32*k +: 32]), 64'(e.instr));
            expect_eq($sformatf("%s pc%0d", tag, k), 64'(out_pc_o[32*k +: 32]), 64'(e.pc));
            expect_eq($sformatf("%s class%0d", tag, k), 64'(out_class_o[CW*k +: CW]), 64'(e.cls));
        end
        expect_eq({tag, " level"}, 64'(level_o), 64'(model_q.size()));
        expect_eq({tag, " accept"}, 64'(fetch_accept_o), 64'((DEPTH - model_q.size()) >= LANES));
    endtask

    task automatic step(input logic fv, input logic [LANES-1:0] lv, input logic [LANES*32-1:0] ins,
                        input logic [31:0] pc, input logic [LANES-1:0] flt, input int pop,
                        input logic fl, input logic md, input string tag);
        bit   acc;
        int   p;
        ent_t e;
        check_outputs(tag);
        fetch_valid_i      = fv;
        fetch_lane_valid_i = lv;
        fetch_instr_i      = ins;
        fetch_pc_i         = pc;
        fetch_fault_i      = flt;
        out_pop_i          = POP_W'(pop);
        flush_i            = fl;
        enable_muldiv_i    = md;
        acc = (DEPTH - model_q.size()) >= LANES;
        if (fl) model_q.delete();
        else begin
            p = (pop > model_q.size()) ? model_q.size() : pop;
            repeat (p) model_q.delete(0);
            if (fv && acc) begin
                for (int j = 0; j < LANES; j++) begin
                    if (lv[j]) begin
                        e.instr = ins[32*j +: 32];
                        e.pc    = pc + 32'(4 * j);
                        e.cls   = model_class(e.instr, flt[j], md);
                        model_q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int pop, input string tag);
        step(1'b0, '0, '0, 32'h0, '0, pop, 1'b0, 1'b1, tag);
    endtask

    initial begin
        logic [31:0]         exp_pc;
        logic [LANES*32-1:0] ins;
        logic [LANES-1:0]    lv, flt;
        int                  cnt, pop, mx;

        rst_ni = 1'b0; enable_muldiv_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0;
        fetch_lane_valid_i = '0; fetch_instr_i = '0; fetch_pc_i = '0; fetch_fault_i = '0;
        out_pop_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        check_outputs("reset");
        expect_eq("reset accept", 64'(fetch_accept_o), 64'd1);

        step(1'b1, 2'b11, {32'h0000a103, 32'h00100093}, 32'h80000000, 2'b00, 0, 1'b0, 1'b1, "addi_lw");
        expect_eq("addi_lw valid", 64'(out_valid_o), 64'b11);
        expect_eq("addi class", 64'(out_class_o[8:0]), 64'h081);
        expect_eq("lw class", 64'(out_class_o[17:9]), 64'h082);
        expect_eq("lw pc", 64'(out_pc_o[63:32]), 64'h80000004);
        idle(2, "drain1");

        step(1'b1, 2'b01, {32'h0, 32'h02208033}, 32'h80000100, 2'b00, 0, 1'b0, 1'b0, "mul_off");
        expect_eq("mul disabled class", 64'(out_class_o[8:0]), 64'h060);
        idle(1, "drain2");
        step(1'b1, 2'b01, {32'h0, 32'h02208033}, 32'h80000104, 2'b00, 0, 1'b0, 1'b1, "mul_on");
        expect_eq("mul enabled class", 64'(out_class_o[8:0]), 64'h088);
        idle(1, "drain3");

        step(1'b1, 2'b11, {32'h00200113, 32'h00100093}, 32'h80000200, 2'b00, 0, 1'b0, 1'b1, "fill_a");
        step(1'b1, 2'b11, {32'h00400213, 32'h00300193}, 32'h80000208, 2'b00, 0, 1'b0, 1'b1, "fill_b");
        expect_eq("full level", 64'(level_o), 64'd4);
        expect_eq("full accept", 64'(fetch_accept_o), 64'd0);
        idle(1, "pop_a");
        expect_eq("level after pop1", 64'(level_o), 64'd3);
        expect_eq("accept at 3", 64'(fetch_accept_o), 64'd0);
        idle(1, "pop_b");
        expect_eq("level after pop2", 64'(level_o), 64'd2);
        expect_eq("accept at 2", 64'(fetch_accept_o), 64'd1);
        idle(2, "drain4");

        exp_pc = 32'h80000000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                expect_eq("wrap pc lane0", 64'(out_pc_o[31:0]), 64'(exp_pc));
                expect_eq("wrap pc lane1", 64'(out_pc_o[63:32]), 64'(exp_pc + 32'd4));
                exp_pc = exp_pc + 32'd8;
            end
            step(1'b1, 2'b11, {32'h00000013, 32'h00000013}, 32'h80000000 + 32'(8 * i), 2'b00,
                 (i > 0) ? 2 : 0, 1'b0, 1'b1, "wrap");
        end
        expect_eq("wrap last pc lane0", 64'(out_pc_o[31:0]), 64'(exp_pc));
        expect_eq("wrap last pc lane1", 64'(out_pc_o[63:32]), 64'(exp_pc + 32'd4));
        idle(2, "drain5");

        step(1'b1, 2'b11, {32'h00000013, 32'h00000013}, 32'h80000300, 2'b00, 0, 1'b0, 1'b1, "pre_fl_a");
        step(1'b1, 2'b01, {32'h0, 32'h00000013}, 32'h80000308, 2'b00, 0, 1'b0, 1'b1, "pre_fl_b");
        expect_eq("pre flush level", 64'(level_o), 64'd3);
        step(1'b1, 2'b11, {32'h00000013, 32'h00000013}, 32'h80000400, 2'b00, 1, 1'b1, 1'b1, "flush");
        expect_eq("flush level", 64'(level_o), 64'd0);
        expect_eq("flush valid", 64'(out_valid_o), 64'd0);

        step(1'b1, 2'b01, {32'h00100093, 32'h00100093}, 32'h80000500, 2'b00, 0, 1'b0, 1'b1, "lv01");
        expect_eq("lv01 level", 64'(level_o), 64'd1);
        step(1'b1, 2'b01, {32'h0, 32'h0}, 32'h80000600, 2'b01, 1, 1'b0, 1'b1, "fault");
        expect_eq("fault class", 64'(out_class_o[8:0]), 64'h120);
        expect_eq("fault rd_valid", 64'(out_class_o[7]), 64'd0);
        idle(1, "drain6");

        for (int i = 0; i < 500; i++) begin
            cnt = $urandom_range(0, LANES);
            lv  = LANES'((1 << cnt) - 1);
            ins = {gen_instr(), gen_instr()};
            for (int j = 0; j < LANES; j++) flt[j] = ($urandom_range(0, 7) == 0);
            mx  = (model_q.size() < LANES) ? model_q.size() : LANES;
            pop = $urandom_range(0, mx);
            step(($urandom_range(0, 3) != 0), lv, ins, $urandom & 32'hffff_fffc, flt, pop,
                 ($urandom_range(0, 19) == 0), 1'($urandom), "rand");
        end
        check_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
